// File: rtl/matrix_pkg.sv
// Shared constants, opcode and state encodings, and the dimension record
// used by the matrix calculation engine.
package matrix_pkg;

    localparam int MAX_DIM   = 5;
    localparam int ELEM_W    = 8;
    localparam int RES_W     = 16;
    localparam int MAX_ELEMS = 25;
    localparam int ACC_W     = 20;

    localparam logic [3:0] OP_TRANSPOSE = 4'd0;
    localparam logic [3:0] OP_ADD       = 4'd1;
    localparam logic [3:0] OP_SCALAR    = 4'd2;
    localparam logic [3:0] OP_MATMUL    = 4'd3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef struct packed {
        logic [2:0] m;
        logic [2:0] n;
    } dim_t;

    function automatic logic dim_ok(input logic [2:0] d);
        return (d != 3'd0) && (d <= 3'(MAX_DIM));
    endfunction

endpackage

// File: rtl/matrix_calc_engine_if.sv
// Request/response bundle of the matrix calculation engine; master issues
// requests, slave (the engine) returns results.
interface matrix_calc_engine_if;
    import matrix_pkg::*;

    logic                           calc_start;
    logic [3:0]                     operation_type;
    logic [5:0]                     matrix_a_dim;
    logic [5:0]                     matrix_b_dim;
    logic [7:0]                     scalar_value;
    logic [MAX_ELEMS*ELEM_W-1:0]    matrix_a_data;
    logic [MAX_ELEMS*ELEM_W-1:0]    matrix_b_data;
    logic [MAX_ELEMS*RES_W-1:0]     result_data;
    logic [5:0]                     result_dim;
    logic                           calc_done;
    logic                           calc_error;
    logic                           busy;

    modport master (
        output calc_start, operation_type, matrix_a_dim, matrix_b_dim,
               scalar_value, matrix_a_data, matrix_b_data,
        input  result_data, result_dim, calc_done, calc_error, busy
    );

    modport slave (
        input  calc_start, operation_type, matrix_a_dim, matrix_b_dim,
               scalar_value, matrix_a_data, matrix_b_data,
        output result_data, result_dim, calc_done, calc_error, busy
    );

endinterface

// File: rtl/matrix_mac.sv
// 8x8 multiply with 20-bit accumulate. Define MATRIX_CALC_SAT_EN to clamp
// the 16-bit result at 16'hFFFF instead of keeping the low 16 bits.
module matrix_mac
    import matrix_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clear,
    input  logic [ELEM_W-1:0] a,
    input  logic [ELEM_W-1:0] b,
    output logic [RES_W-1:0]  raw_res,
    output logic [RES_W-1:0]  res
);

    logic [ACC_W-1:0]    acc_reg;
    logic [2*ELEM_W-1:0] product;
    logic [ACC_W-1:0]    sum;

    assign product = a * b;
    // clear starts a new dot product without a dead cycle
    assign sum     = (clear ? '0 : acc_reg) + ACC_W'(product);
    assign raw_res = sum[RES_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg <= '0;
        end else if (en) begin
            acc_reg <= sum;
        end
    end

`ifdef MATRIX_CALC_SAT_EN
    assign res = (sum > ACC_W'(20'h0FFFF)) ? '1 : sum[RES_W-1:0];
`else
    assign res = sum[RES_W-1:0];
`endif

endmodule

// File: rtl/matrix_calc_engine.sv
// Matrix engine: transpose, add, scalar multiply and matrix multiply on up
// to 5x5 operands, one element/MAC per cycle. Honours MATRIX_CALC_SAT_EN via matrix_mac.
module matrix_calc_engine
    import matrix_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    matrix_calc_engine_if.slave  bus
);

    logic [1:0]        state_reg;
    logic [3:0]        op_reg;
    dim_t              a_dim_reg;
    dim_t              b_dim_reg;
    dim_t              res_dim_reg;
    logic [7:0]        scalar_reg;
    logic [ELEM_W-1:0] a_mem   [MAX_ELEMS];
    logic [ELEM_W-1:0] b_mem   [MAX_ELEMS];
    logic [RES_W-1:0]  res_mem [MAX_ELEMS];
    logic [2:0]        r_reg, c_reg, k_reg;
    logic              done_reg, error_reg, busy_reg;

    logic              start_accept;
    logic              legal;
    dim_t              res_dim_next;
    logic [2:0]        c_lim, k_lim;
    logic              k_last, c_last, r_last;
    logic [4:0]        a_row, a_idx, b_idx, dst_idx;
    logic [ELEM_W-1:0] a_val, b_val, mac_b;
    logic              wr_en, is_mm;
    logic [RES_W-1:0]  wr_data, mac_raw, mac_res;

    assign start_accept = (state_reg == ST_IDLE) && bus.calc_start;
    assign is_mm        = (op_reg == OP_MATMUL);

    always_comb begin
        legal        = 1'b0;
        res_dim_next = a_dim_reg;
        case (op_reg)
            OP_TRANSPOSE: begin
                legal        = dim_ok(a_dim_reg.m) && dim_ok(a_dim_reg.n);
                res_dim_next = '{m: a_dim_reg.n, n: a_dim_reg.m};
            end
            OP_ADD:    legal = dim_ok(a_dim_reg.m) && dim_ok(a_dim_reg.n) &&
                               (a_dim_reg == b_dim_reg);
            OP_SCALAR: legal = dim_ok(a_dim_reg.m) && dim_ok(a_dim_reg.n);
            OP_MATMUL: begin
                legal        = dim_ok(a_dim_reg.m) && dim_ok(a_dim_reg.n) &&
                               dim_ok(b_dim_reg.m) && dim_ok(b_dim_reg.n) &&
                               (a_dim_reg.n == b_dim_reg.m);
                res_dim_next = '{m: a_dim_reg.m, n: b_dim_reg.n};
            end
            default:   legal = 1'b0;
        endcase
    end

    // Loop nest r (rows of A) / c (result columns) / k (dot-product term);
    // k collapses to a single pass for the element-wise operations.
    assign c_lim  = is_mm ? b_dim_reg.n : a_dim_reg.n;
    assign k_lim  = is_mm ? a_dim_reg.n : 3'd1;
    assign k_last = (k_reg == k_lim - 3'd1);
    assign c_last = (c_reg == c_lim - 3'd1);
    assign r_last = (r_reg == a_dim_reg.m - 3'd1);

    assign a_row = 5'(r_reg) * 5'(a_dim_reg.n);
    assign a_idx = a_row + 5'(is_mm ? k_reg : c_reg);
    assign b_idx = is_mm ? 5'(k_reg) * 5'(b_dim_reg.n) + 5'(c_reg)
                         : a_row + 5'(c_reg);

    always_comb begin
        case (op_reg)
            OP_TRANSPOSE: dst_idx = 5'(c_reg) * 5'(a_dim_reg.m) + 5'(r_reg);
            OP_MATMUL:    dst_idx = 5'(r_reg) * 5'(b_dim_reg.n) + 5'(c_reg);
            default:      dst_idx = a_row + 5'(c_reg);
        endcase
    end

    assign a_val = a_mem[a_idx];
    assign b_val = b_mem[b_idx];
    assign mac_b = (op_reg == OP_SCALAR) ? scalar_reg : b_val;
    assign wr_en = (state_reg == ST_RUN) && k_last;

    matrix_mac u_mac (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (state_reg == ST_RUN),
        .clear   (k_reg == 3'd0),
        .a       (a_val),
        .b       (mac_b),
        .raw_res (mac_raw),
        .res     (mac_res)
    );

    always_comb begin
        case (op_reg)
            OP_TRANSPOSE: wr_data = RES_W'(a_val);
            OP_ADD:       wr_data = RES_W'({1'b0, a_val} + {1'b0, b_val});
            OP_SCALAR:    wr_data = mac_raw;
            default:      wr_data = mac_res;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_ELEMS; i++) begin
                a_mem[i]   <= '0;
                b_mem[i]   <= '0;
                res_mem[i] <= '0;
            end
        end else if (start_accept) begin
            for (int i = 0; i < MAX_ELEMS; i++) begin
                a_mem[i]   <= bus.matrix_a_data[i*ELEM_W +: ELEM_W];
                b_mem[i]   <= bus.matrix_b_data[i*ELEM_W +: ELEM_W];
                res_mem[i] <= '0;
            end
        end else if (wr_en) begin
            res_mem[dst_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            op_reg      <= '0;
            a_dim_reg   <= '0;
            b_dim_reg   <= '0;
            scalar_reg  <= '0;
            res_dim_reg <= '0;
            r_reg       <= '0;
            c_reg       <= '0;
            k_reg       <= '0;
            done_reg    <= 1'b0;
            error_reg   <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (bus.calc_start) begin
                        state_reg  <= ST_CHECK;
                        op_reg     <= bus.operation_type;
                        a_dim_reg  <= bus.matrix_a_dim;
                        b_dim_reg  <= bus.matrix_b_dim;
                        scalar_reg <= bus.scalar_value;
                        error_reg  <= 1'b0;
                        busy_reg   <= 1'b1;
                        r_reg      <= '0;
                        c_reg      <= '0;
                        k_reg      <= '0;
                    end
                end
                ST_CHECK: begin
                    if (legal) begin
                        state_reg   <= ST_RUN;
                        res_dim_reg <= res_dim_next;
                    end else begin
                        state_reg   <= ST_DONE;
                        res_dim_reg <= '0;
                        error_reg   <= 1'b1;
                        done_reg    <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (k_last) begin
                        k_reg <= '0;
                        if (c_last) begin
                            c_reg <= '0;
                            if (r_last) begin
                                state_reg <= ST_DONE;
                                done_reg  <= 1'b1;
                            end else begin
                                r_reg <= r_reg + 3'd1;
                            end
                        end else begin
                            c_reg <= c_reg + 3'd1;
                        end
                    end else begin
                        k_reg <= k_reg + 3'd1;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < MAX_ELEMS; gi++) begin : g_res
            assign bus.result_data[gi*RES_W +: RES_W] = res_mem[gi];
        end
    endgenerate

    assign bus.result_dim = res_dim_reg;
    assign bus.calc_done  = done_reg;
    assign bus.calc_error = error_reg;
    assign bus.busy       = busy_reg;

endmodule

// File: tb/tb_matrix_calc_engine.sv
// Directed bench for matrix_calc_engine: legal/illegal ops, latency, operand
// isolation, DONE-cycle start and mid-operation reset.
module tb_matrix_calc_engine;

    logic clk;
    logic rst_n;
    int   vec_cnt;
    int   err_cnt;
    int   av [25];
    int   bv [25];
    int   ev [25];

    matrix_calc_engine_if bus ();

    matrix_calc_engine dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef MATRIX_CALC_SAT_EN
    localparam int MM_FULL = 65535;
`else
    localparam int MM_FULL = 62981;
`endif

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic apply(input string tag, input logic [3:0] op, input logic [5:0] adim,
                         input logic [5:0] bdim, input logic [7:0] k, input logic [5:0] exp_dim,
                         input logic exp_err, input int exp_lat, input bit disturb);
        int lat;
        int dones;
        for (int i = 0; i < 25; i++) begin
            bus.matrix_a_data[i*8 +: 8] = 8'(av[i]);
            bus.matrix_b_data[i*8 +: 8] = 8'(bv[i]);
        end
        bus.operation_type = op;
        bus.matrix_a_dim   = adim;
        bus.matrix_b_dim   = bdim;
        bus.scalar_value   = k;
        @(negedge clk);
        bus.calc_start = 1'b1;
        @(negedge clk);
        bus.calc_start = 1'b0;
        lat = 1;
        check_eq({tag, "_busy"}, 32'(bus.busy), 32'd1);
        while (!bus.calc_done && lat < 400) begin
            if (disturb && lat == 4) begin
                bus.calc_start     = 1'b1;
                bus.matrix_a_data  = ~bus.matrix_a_data;
                bus.matrix_b_data  = ~bus.matrix_b_data;
                bus.operation_type = 4'd1;
                bus.matrix_a_dim   = 6'o55;
                bus.matrix_b_dim   = 6'o55;
            end
            if (disturb && lat == 5) bus.calc_start = 1'b0;
            @(negedge clk);
            lat++;
        end
        check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, "_err"}, 32'(bus.calc_error), 32'(exp_err));
        check_eq({tag, "_dim"}, 32'(bus.result_dim), 32'(exp_dim));
        for (int i = 0; i < 25; i++)
            check_eq($sformatf("%s_res%0d", tag, i), 32'(bus.result_data[i*16 +: 16]), 32'(ev[i]));
        $display("op %s: latency %0d error %0d dim %0o", tag, lat, bus.calc_error, bus.result_dim);
        // a start during the DONE cycle must be dropped
        if (disturb) bus.calc_start = 1'b1;
        @(negedge clk);
        bus.calc_start = 1'b0;
        check_eq({tag, "_err_hold"}, 32'(bus.calc_error), 32'(exp_err));
        check_eq({tag, "_idle"}, 32'(bus.busy), 32'd0);
        dones = 0;
        repeat (20) begin
            @(negedge clk);
            dones += int'(bus.calc_done);
        end
        check_eq({tag, "_extra_done"}, 32'(dones), 32'd0);
    endtask

    initial begin
        int dones;
        vec_cnt = 0;
        err_cnt = 0;
        rst_n              = 1'b0;
        bus.calc_start     = 1'b0;
        bus.operation_type = '0;
        bus.matrix_a_dim   = '0;
        bus.matrix_b_dim   = '0;
        bus.scalar_value   = '0;
        bus.matrix_a_data  = '0;
        bus.matrix_b_data  = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_res", 32'(|bus.result_data), 32'd0);
        check_eq("rst_dim", 32'(bus.result_dim), 32'd0);
        check_eq("rst_done", 32'(bus.calc_done), 32'd0);
        check_eq("rst_err", 32'(bus.calc_error), 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);

        av = '{0:1, 1:2, 2:3, 3:4, 4:5, 5:6, default:0};
        bv = '{default:0};
        ev = '{0:1, 1:4, 2:2, 3:5, 4:3, 5:6, default:0};
        apply("transpose", 4'd0, {3'd2, 3'd3}, 6'd0, 8'd0, {3'd3, 3'd2}, 1'b0, 8, 1'b0);

        av = '{0:255, 1:1, 2:2, 3:3, default:0};
        bv = '{0:255, default:0};
        ev = '{0:510, 1:1, 2:2, 3:3, default:0};
        apply("add", 4'd1, {3'd2, 3'd2}, {3'd2, 3'd2}, 8'd0, {3'd2, 3'd2}, 1'b0, 6, 1'b0);

        ev = '{default:0};
        apply("add_dim_mis", 4'd1, {3'd2, 3'd2}, {3'd2, 3'd3}, 8'd0, 6'd0, 1'b1, 2, 1'b0);

        av = '{default:255};
        bv = '{default:255};
        ev = '{default:MM_FULL};
        apply("mm5x5", 4'd3, {3'd5, 3'd5}, {3'd5, 3'd5}, 8'd0, {3'd5, 3'd5}, 1'b0, 127, 1'b0);

        av = '{0:7, 1:0, 2:255, default:0};
        bv = '{default:99};
        ev = '{0:1785, 1:0, 2:65025, default:0};
        apply("scalar", 4'd2, {3'd3, 3'd1}, 6'd0, 8'd255, {3'd3, 3'd1}, 1'b0, 5, 1'b0);

        av = '{0:1, 1:2, 2:3, 3:4, 4:5, 5:6, default:0};
        bv = '{0:7, 1:8, 2:9, 3:10, 4:11, 5:12, default:0};
        ev = '{0:58, 1:64, 2:139, 3:154, default:0};
        apply("mm2x3x2", 4'd3, {3'd2, 3'd3}, {3'd3, 3'd2}, 8'd0, {3'd2, 3'd2}, 1'b0, 14, 1'b0);
        apply("mm_disturb", 4'd3, {3'd2, 3'd3}, {3'd3, 3'd2}, 8'd0, {3'd2, 3'd2}, 1'b0, 14, 1'b1);

        ev = '{default:0};
        apply("bad_op", 4'd5, {3'd2, 3'd2}, {3'd2, 3'd2}, 8'd0, 6'd0, 1'b1, 2, 1'b0);
        apply("dim_zero", 4'd0, {3'd0, 3'd3}, 6'd0, 8'd0, 6'd0, 1'b1, 2, 1'b0);
        apply("dim_six", 4'd2, {3'd6, 3'd1}, 6'd0, 8'd3, 6'd0, 1'b1, 2, 1'b0);
        apply("mm_inner", 4'd3, {3'd2, 3'd3}, {3'd2, 3'd2}, 8'd0, 6'd0, 1'b1, 2, 1'b0);

        // reset in the middle of a long matmul
        av = '{default:255};
        bv = '{default:255};
        for (int i = 0; i < 25; i++) begin
            bus.matrix_a_data[i*8 +: 8] = 8'(av[i]);
            bus.matrix_b_data[i*8 +: 8] = 8'(bv[i]);
        end
        bus.operation_type = 4'd3;
        bus.matrix_a_dim   = {3'd5, 3'd5};
        bus.matrix_b_dim   = {3'd5, 3'd5};
        @(negedge clk);
        bus.calc_start = 1'b1;
        @(negedge clk);
        bus.calc_start = 1'b0;
        repeat (20) @(negedge clk);
        check_eq("midrst_busy_pre", 32'(bus.busy), 32'd1);
        check_eq("midrst_partial", 32'(|bus.result_data), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_res", 32'(|bus.result_data), 32'd0);
        check_eq("midrst_dim", 32'(bus.result_dim), 32'd0);
        check_eq("midrst_busy", 32'(bus.busy), 32'd0);
        check_eq("midrst_done", 32'(bus.calc_done), 32'd0);
        check_eq("midrst_err", 32'(bus.calc_error), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (150) begin
            @(negedge clk);
            dones += int'(bus.calc_done);
        end
        check_eq("midrst_no_done", 32'(dones), 32'd0);
        $display("op midrst: reset applied during matmul");

        av = '{0:1, 1:2, 2:3, 3:4, 4:5, 5:6, default:0};
        bv = '{default:0};
        ev = '{0:1, 1:4, 2:2, 3:5, 4:3, 5:6, default:0};
        apply("post_rst", 4'd0, {3'd2, 3'd3}, 6'd0, 8'd0, {3'd3, 3'd2}, 1'b0, 8, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/matrix_calc_engine.md
MATRIX_CALC_ENGINE -- requirements
Module: matrix_calc_engine

Interface
REQ-001 clk  in  1  sole clock; all state on rising edge.
REQ-002 rst_n  in  1  asynchronous, active-low reset.
REQ-003 calc_start  in  1  single-cycle request; ignored while busy=1.
REQ-004 operation_type  in  4  0 transpose, 1 add, 2 scalar multiply, 3 matrix multiply, others invalid.
REQ-005 matrix_a_dim / matrix_b_dim  in  6 each  {m[5:3], n[2:0]}.
REQ-006 scalar_value  in  8  unsigned scalar for op 2.
REQ-007 matrix_a_data / matrix_b_data  in  200 each  25 x 8-bit unsigned, row-major, element i at [i*8 +: 8].
REQ-008 result_data  out  400  25 x 16-bit unsigned, row-major, element i at [i*16 +: 16].
REQ-009 result_dim  out  6  {m[5:3], n[2:0]} of result.
REQ-010 calc_done  out  1  one-cycle completion pulse.
REQ-011 calc_error  out  1  valid with calc_done; held until next accepted start.
REQ-012 busy  out  1  high from the cycle after an accepted start through the calc_done cycle.

Function
REQ-013 States: IDLE, CHECK, RUN, DONE; IDLE->CHECK on calc_start; CHECK->RUN if legal, else ->DONE with error; RUN->DONE after last element; DONE->IDLE unconditionally.
REQ-014 On accepted start, the block shall latch op, dims, scalar and both operand vectors, so that upstream input changes during the operation have no effect.
REQ-015 On accepted start, the block shall clear result_data to 0 and calc_error to 0.
REQ-016 Legality: every used dimension in 1..5; add requires A.dim==B.dim; matmul requires A.n==B.m; op>3 is illegal; B is ignored for ops 0 and 2.
REQ-017 Illegal request: calc_done pulses 2 cycles after start with calc_error=1, result_data=0 and result_dim=0.
REQ-018 Transpose: result_dim={A.n,A.m}; res[c*A.m+r]=A[r*A.n+c]; one element per RUN cycle.
REQ-019 Add: res[i]=A[i]+B[i], 9-bit result zero-extended; one element per cycle; result_dim=A.dim.
REQ-020 Scalar: res[i]=A[i]*scalar_value, 16-bit exact; one element per cycle.
REQ-021 Matmul: res[r*B.n+c]=sum_k A[r*A.n+k]*B[k*B.n+c]; one MAC per RUN cycle using a 20-bit accumulator; result_dim={A.m,B.n}.
REQ-022 Latency from start to calc_done: 2+m*n cycles for ops 0-2; 2+A.m*B.n*A.n cycles for op 3.
REQ-023 Unused result slots (index >= m*n) shall remain 0.
REQ-024 calc_start asserted during the DONE cycle shall be ignored; a new request is accepted only in IDLE.

Reset
REQ-025 Reset shall force state IDLE and clear result_data, result_dim, calc_done, calc_error, busy and all latched operands to 0.
REQ-026 Reset asserted mid-operation shall abort the operation without emitting calc_done.

Configuration
REQ-027 With MATRIX_CALC_SAT_EN defined, each matmul result above 16'hFFFF shall be stored as 16'hFFFF.
REQ-028 Without MATRIX_CALC_SAT_EN, each matmul result shall be the low 16 bits of the accumulator; ops 0-2 are unaffected in both builds.

Structure
REQ-029 Shared package matrix_pkg shall hold: opcode constants, MAX_DIM=5, ELEM_W=8, RES_W=16, MAX_ELEMS=25, and the state encoding.
REQ-030 Sub-module matrix_mac shall implement the 8x8 multiply, 20-bit accumulate, clear and the MATRIX_CALC_SAT_EN output stage; it shall be reused for op 2.

Verification
REQ-031 Transpose with A=2x3 [1 2 3;4 5 6] -> result_dim {3,2}, result [1 4;2 5;3 6], calc_done at start+8, calc_error=0.
REQ-032 Add with 2x2 A=[255 1;2 3] and B=[255 0;0 0] -> result [510 1;2 3]; add with A=2x2 and B=2x3 -> calc_error=1 at start+2, result_data=0.
REQ-033 Matmul 5x5 with all elements 255 -> 25 elements of 325125; SAT_EN build gives 65535, non-SAT build gives 325125 mod 65536 = 62981; calc_done at start+127.
REQ-034 Scalar 3x1 A=[7 0 255], k=255 -> result [1785 0 65025], all higher slots 0.
REQ-035 Second calc_start during RUN plus operand change mid-RUN -> result reflects the first request only, and exactly one calc_done is produced.
REQ-036 rst_n pulsed low mid-matmul -> all outputs 0 and no calc_done; a new start after reset completes normally.
